serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder. Loads two operands and a carry-in on a start request.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/full_adder_dataflow.sv | 11 +
 rtl/serial_adder.sv | 80 ++++++++
 tb/tb_serial_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and sizing helpers for the bit-serial adder
package serial_adder_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/full_adder_dataflow.sv
// full_adder_dataflow: combinational one-bit full adder
module full_adder_dataflow (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder feeding one full-adder cell LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
    logic [CW-1:0]    cnt;
    logic             carry, fa_sum, fa_carry, last;

    full_adder_dataflow u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last = cnt == CW'(WIDTH - 1);
    // shift form keeps WIDTH=1 legal (no reversed part-select)
    assign res_next = (res_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = (state == S_IDLE)  ? (start ? S_SHIFT : S_IDLE) :
                     (state == S_SHIFT) ? (last ? S_DONE : S_SHIFT) : S_IDLE;
    end

    always_comb begin
        busy = state != S_IDLE;
        done = state == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else if (state == S_IDLE && start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= fa_carry;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum_out <= res_next;
                cout    <= fa_carry;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors with a queue scoreboard for WIDTH=8 and WIDTH=1 instances
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic busy1, done1, sum1, cout1;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    int   vecs = 0;
    int   errs = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a), .b_in(b), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            check("sb_pending", 64'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("sum_out", sum, e.s);
                check("cout", cout, e.c);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done1 === 1'b1) begin
            exp_t e;
            check("sb1_pending", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("sum_out_w1", sum1, e.s);
                check("cout_w1", cout1, e.c);
            end
        end
    end

    task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                         input logic push, input logic [7:0] es, input logic ec);
        @(negedge clk);
        a = ai; b = bi; cin = ci; start = 1'b1;
        if (push) q.push_back({es, ec});
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    endtask

    task automatic issue1(input logic ai, input logic bi, input logic ci,
                          input logic es, input logic ec);
        @(negedge clk);
        a1 = ai; b1 = bi; cin1 = ci; start1 = 1'b1;
        q1.push_back({7'd0, es, ec});
        @(negedge clk);
        start1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_done1(output int k);
        k = 0;
        while (done1 !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, nb, nd, dpos, firstpos, lastpos, sp_bad, unstable;
        logic [7:0] ts, tc;
        ts = 8'b1001_0110;
        tc = 8'b1110_1000;

        // power-on reset
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // 0x3C + 0x42: busy window and done position
        issue(8'h3C, 8'h42, 1'b0, 1'b1, 8'h7E, 1'b0);
        nb = 0; nd = 0; dpos = -1;
        for (int i = 0; i < 12; i++) begin
            if (busy) nb++;
            if (done) begin nd++; dpos = i; end
            @(negedge clk);
        end
        check("busy_cycles", nb, 9);
        check("done_pos", dpos, 8);
        check("done_count", nd, 1);

        // asynchronous reset mid-simulation clears held result
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_sum", sum, 0);
        check("async_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        // carry-out boundary cases
        issue(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
        wait_done(k);
        check("latency_ff01", k, 8);
        issue(8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1);
        wait_done(k);
        check("latency_a55a", k, 8);

        // start held high: back-to-back ops, operands scrambled while shifting
        repeat (3) q.push_back({8'h30, 1'b0});
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        nd = 0; firstpos = -1; lastpos = 0; sp_bad = 0; unstable = 0;
        for (int i = 1; i <= 40 && nd < 3; i++) begin
            @(negedge clk);
            if (nd > 0 && sum !== 8'h30) unstable++;
            if (done) begin
                if (nd > 0 && i - lastpos != 10) sp_bad++;
                if (nd == 0) firstpos = i;
                lastpos = i;
                nd++;
                if (nd == 3) start = 1'b0;
            end
            if (busy && !done) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end else begin
                a = 8'h10; b = 8'h20; cin = 1'b0;
            end
        end
        check("held_ops", nd, 3);
        check("held_first_done", firstpos, 9);
        check("held_spacing_bad", sp_bad, 0);
        check("held_sum_unstable", unstable, 0);

        // reset at the 4th shift cycle aborts the add
        issue(8'h0F, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        issue(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);
        wait_done(k);
        check("latency_0101", k, 8);

        // WIDTH=1 exhaustive full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            issue1(v[2], v[1], v[0], ts[i], tc[i]);
            wait_done1(k);
            check("latency_w1", k, 1);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", q.size(), 0);
        check("sb1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
